cpu_boot_loader: RTL and testbench
==================================

# cpu_boot_loader

Program loader and run supervisor that sits directly upstream of the 8-bit accumulator CPU. It accepts a byte stream over a valid/ready handshake and writes it into CPU memory from address 0 upward while holding the CPU in reset. It then releases the CPU, counts execution cycles until the CPU raises `halt`, and reports completion or load overflow.

## Interface
- `DEFAULT_WORD_W`, 8, memory word / stream byte width
- `ADDR_WIDTH`, 5, memory address width; depth = 2**ADDR_WIDTH
- `CYCLE_W`, 16, width of run-cycle counter

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a load
- `s_valid`  in  1  stream byte valid
- `s_data`  in  DEFAULT_WORD_W  stream byte (program word)
- `s_last`  in  1  marks final byte of program
- `s_ready`  out  1  loader accepts byte this cycle
- `mem_sel`  out  1  1 = loader owns memory port, 0 = CPU owns it
- `mem_wr`  out  1  memory write strobe
- `mem_addr`  out  ADDR_WIDTH  write address
- `mem_data`  out  DEFAULT_WORD_W  write data
- `cpu_rst_n`  out  1  CPU reset, active-low; low = CPU held
- `cpu_halt`  in  1  CPU halt indication
- `done`  out  1  CPU halted after a successful load
- `error`  out  1  program overflowed memory (no `s_last` by last address)
- `run_cycles`  out  CYCLE_W  cycles spent in RUN

## Operation
- States: IDLE, LOAD, RUN, HALTED, ERROR.
- IDLE: `mem_sel`=1, `cpu_rst_n`=0, `s_ready`=0. `start` -> LOAD; write pointer and `run_cycles` cleared to 0.
- LOAD: `s_ready`=1, `cpu_rst_n`=0, `mem_sel`=1. Each handshake (`s_valid && s_ready`) latches `s_data` and the write pointer; the pointer increments by 1.
  - Handshake with `s_last`=1 -> RUN; `s_ready` drops the following cycle.
  - Handshake at pointer = 2**ADDR_WIDTH-1 with `s_last`=0 -> ERROR; that byte is still written.
  - Pointer never wraps.
- RUN: `mem_sel`=0, `cpu_rst_n`=1. `run_cycles` increments every RUN cycle and saturates at all-ones. `cpu_halt` sampled high -> HALTED; the counter does not increment on that cycle.
- HALTED: `done`=1, `cpu_rst_n`=1 (CPU stays halted), `run_cycles` frozen.
- ERROR: `error`=1, `cpu_rst_n`=0, `mem_sel`=1.
- `start` is accepted in IDLE, HALTED and ERROR, and is ignored in LOAD and RUN. Accepting `start` -> LOAD, with `done`/`error` cleared, counters zeroed and `cpu_rst_n`=0 the next cycle.
- `cpu_halt` is ignored outside RUN.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `s_ready`=0, `mem_sel`=1, `mem_wr`=0, `mem_addr`=0, `mem_data`=0, `cpu_rst_n`=0, `done`=0, `error`=0, `run_cycles`=0.
- Write latency: handshake in cycle N -> `mem_wr`=1 with that address/data in cycle N+1, a single-cycle pulse. Back-to-back handshakes give back-to-back writes.
- `mem_sel` stays 1 through the cycle carrying the final write; it drops one cycle later.
- `cpu_rst_n` rises in the first cycle that `mem_sel`=0. That cycle is counted as run cycle 1.
- `start` in IDLE at cycle N -> `s_ready`=1 at N+1.
- `rst` mid-LOAD: any pending write is cancelled (no `mem_wr` the cycle after `rst`), all outputs go to their reset values.
- `rst` and `start` together: `rst` wins.

## Structure
- Shared typedefs package gets `boot_state_e` (the five states, 3-bit encoding) and the default `CYCLE_W` constant.
- One natural sub-module, `boot_cycle_counter`: a saturating up-counter with clear and enable, used for `run_cycles`.
- The write pointer lives inline.

## Test plan
- Load 4 bytes 0xA0,0x21,0xC3,0x00 (last on 4th), `s_valid` held high -> writes to addresses 0..3 on 4 consecutive cycles, `cpu_rst_n` rises 2 cycles after the last handshake.
- Stall `s_valid` randomly during a 10-byte load -> exactly 10 writes, addresses 0..9 in order, data matches the stream.
- RUN, then drive `cpu_halt` high 37 cycles after `cpu_rst_n` rises -> `done`=1, `run_cycles`=37 and stable; a `cpu_halt` toggle afterwards has no effect.
- Send 32 bytes with no `s_last` (ADDR_WIDTH=5) -> 32 writes, `error`=1 the cycle after the 32nd write, `cpu_rst_n` stays 0. Then `start` -> LOAD with `error`=0.
- Assert `rst` after 3 of 6 bytes -> no further `mem_wr`, all outputs at reset values. `start` plus a 6-byte reload writes from address 0.
- With CYCLE_W=4 and no halt for 20 RUN cycles -> `run_cycles` saturates at 15. A `start` pulse during RUN is ignored.

Source files
------------

// File: rtl/cpu_boot_loader_pkg.sv
// ============================================================================
// Module   : cpu_boot_loader_pkg
// Brief    : Shared state encoding and default sizes for the boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_boot_loader_pkg;

    localparam int CYCLE_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_HALTED = 3'd3,
        ST_ERROR  = 3'd4
    } boot_state_e;

endpackage : cpu_boot_loader_pkg

`default_nettype wire

// File: rtl/cpu_boot_loader_cycle_counter.sv
// ============================================================================
// Module   : boot_cycle_counter
// Brief    : Saturating up-counter with synchronous clear and count enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_cycle_counter
    import cpu_boot_loader_pkg::*;
#(
    parameter int WIDTH = CYCLE_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : boot_cycle_counter

`default_nettype wire

// File: rtl/cpu_boot_loader.sv
// ============================================================================
// Module   : cpu_boot_loader
// Brief    : Streams a program into CPU memory, releases the CPU, times the run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_boot_loader
    import cpu_boot_loader_pkg::*;
#(
    parameter int DEFAULT_WORD_W = 8,
    parameter int ADDR_WIDTH     = 5,
    parameter int CYCLE_W        = CYCLE_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      s_valid,
    input  logic [DEFAULT_WORD_W-1:0] s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic                      mem_sel,
    output logic                      mem_wr,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DEFAULT_WORD_W-1:0] mem_data,
    output logic                      cpu_rst_n,
    input  logic                      cpu_halt,
    output logic                      done,
    output logic                      error,
    output logic [CYCLE_W-1:0]        run_cycles
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};

    boot_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
    logic                      s_ready_q, s_ready_d;
    logic                      mem_sel_q, mem_sel_d;
    logic                      mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [DEFAULT_WORD_W-1:0] mem_data_q, mem_data_d;
    logic                      cpu_rst_n_q, cpu_rst_n_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic                      handshake;
    logic                      accept_start;
    logic                      cpu_owns_now;
    logic                      cpu_owns_next;
    logic                      count_en;

    assign handshake    = s_valid && s_ready_q;
    assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_HALTED) ||
                                    (state_q == ST_ERROR));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (handshake) begin
                    if (s_last)                 state_d = ST_RUN;
                    else if (ptr_q == PTR_MAX)  state_d = ST_ERROR;
                end
            end
            ST_RUN: begin
                if (cpu_halt) state_d = ST_HALTED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CPU takes the memory port one cycle after entering RUN so the final
    // write lands while the loader still owns it; leaving RUN/HALTED drops it at once.
    assign cpu_owns_now  = (state_q == ST_RUN) || (state_q == ST_HALTED);
    assign cpu_owns_next = (state_d == ST_RUN) || (state_d == ST_HALTED);

    always_comb begin
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_wr_d    = handshake;
        s_ready_d   = (state_d == ST_LOAD);
        mem_sel_d   = !(cpu_owns_now && cpu_owns_next);
        cpu_rst_n_d = cpu_owns_now && cpu_owns_next;
        done_d      = (state_q == ST_HALTED) && (state_d == ST_HALTED);
        error_d     = (state_q == ST_ERROR) && (state_d == ST_ERROR);
        if (accept_start) begin
            ptr_d = '0;
        end else if (handshake) begin
            mem_addr_d = ptr_q;
            mem_data_d = s_data;
            if (ptr_q != PTR_MAX) ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            s_ready_q   <= 1'b0;
            mem_sel_q   <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            s_ready_q   <= s_ready_d;
            mem_sel_q   <= mem_sel_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Only cycles in which the CPU is actually out of reset are counted.
    assign count_en = (state_q == ST_RUN) && cpu_rst_n_q && !cpu_halt;

    boot_cycle_counter #(
        .WIDTH (CYCLE_W)
    ) u_run_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_start),
        .en    (count_en),
        .count (run_cycles)
    );

    assign s_ready   = s_ready_q;
    assign mem_sel   = mem_sel_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule : cpu_boot_loader

`default_nettype wire

// File: tb/tb_cpu_boot_loader.sv
// ============================================================================
// Module   : tb_cpu_boot_loader
// Brief    : Directed vector bench for cpu_boot_loader (16- and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_boot_loader;

    logic       clk = 1'b0;
    logic       rst, start, s_valid, s_last, cpu_halt;
    logic [7:0] s_data;

    logic        s_ready, mem_sel, mem_wr, cpu_rst_n, done, error;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [15:0] run_cycles;

    logic        s_ready4, mem_sel4, mem_wr4, cpu_rst_n4, done4, error4;
    logic [4:0]  mem_addr4;
    logic [7:0]  mem_data4;
    logic [3:0]  run_cycles4;

    always #5 clk = ~clk;

    cpu_boot_loader #(.DEFAULT_WORD_W(8), .ADDR_WIDTH(5), .CYCLE_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .mem_sel(mem_sel), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_rst_n(cpu_rst_n),
        .cpu_halt(cpu_halt), .done(done), .error(error), .run_cycles(run_cycles)
    );

    cpu_boot_loader #(.DEFAULT_WORD_W(8), .ADDR_WIDTH(5), .CYCLE_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready4), .mem_sel(mem_sel4), .mem_wr(mem_wr4),
        .mem_addr(mem_addr4), .mem_data(mem_data4), .cpu_rst_n(cpu_rst_n4),
        .cpu_halt(cpu_halt), .done(done4), .error(error4), .run_cycles(run_cycles4)
    );

    typedef struct {
        logic        start, s_valid;
        logic [7:0]  s_data;
        logic        s_last;
        logic        e_ready, e_wr;
        logic [4:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_sel, e_rstn, e_done, e_err;
        logic [15:0] e_rc;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int passed = 0;

    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    always @(negedge clk) begin
        if (mem_wr) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                                input logic l, input logic rdy, input logic wr,
                                input logic [4:0] a, input logic [7:0] wd, input logic sel,
                                input logic rn, input logic [15:0] rc);
        vec_t r;
        r.start = st; r.s_valid = v; r.s_data = d; r.s_last = l;
        r.e_ready = rdy; r.e_wr = wr; r.e_addr = a; r.e_data = wd;
        r.e_sel = sel; r.e_rstn = rn; r.e_done = 1'b0; r.e_err = 1'b0; r.e_rc = rc;
        return r;
    endfunction

    function automatic logic [7:0] byte_at(input logic [7:0] base, input int i);
        return base + 8'(i * 13);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, " s_ready"},    32'(s_ready),    32'd0);
        chk({tag, " mem_sel"},    32'(mem_sel),    32'd1);
        chk({tag, " mem_wr"},     32'(mem_wr),     32'd0);
        chk({tag, " mem_addr"},   32'(mem_addr),   32'd0);
        chk({tag, " mem_data"},   32'(mem_data),   32'd0);
        chk({tag, " cpu_rst_n"},  32'(cpu_rst_n),  32'd0);
        chk({tag, " done"},       32'(done),       32'd0);
        chk({tag, " error"},      32'(error),      32'd0);
        chk({tag, " run_cycles"}, 32'(run_cycles), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_bytes(input int n, input logic last_on_final, input bit stall,
                              input logic [7:0] base);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 500) begin
            s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = byte_at(base, sent);
            s_last  = last_on_final && (sent == n - 1);
            if (s_valid && s_ready) sent++;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (sent < n) chk("load timeout bytes sent", 32'(sent), 32'(n));
    endtask

    task automatic check_writes(input string tag, input int n, input logic [7:0] base);
        chk({tag, " write count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 32'(wr_addr_q[i]), 32'(i));
            chk($sformatf("%s data[%0d]", tag, i), 32'(wr_data_q[i]), 32'(byte_at(base, i)));
        end
    endtask

    task automatic wait_cpu_release(input string tag);
        int guard = 0;
        while (!cpu_rst_n && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, " cpu release"}, 32'(cpu_rst_n), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        cpu_halt = 1'b0;

        //               st v  data   l  rdy wr addr data  sel rn rc
        vecs[0] = mk(1, 0, 8'h00, 0, 0, 0, 5'd0, 8'h00, 1, 0, 16'd0);
        vecs[1] = mk(0, 1, 8'hA0, 0, 1, 0, 5'd0, 8'h00, 1, 0, 16'd0);
        vecs[2] = mk(0, 1, 8'h21, 0, 1, 1, 5'd0, 8'hA0, 1, 0, 16'd0);
        vecs[3] = mk(0, 1, 8'hC3, 0, 1, 1, 5'd1, 8'h21, 1, 0, 16'd0);
        vecs[4] = mk(0, 1, 8'h00, 1, 1, 1, 5'd2, 8'hC3, 1, 0, 16'd0);
        vecs[5] = mk(0, 0, 8'h00, 0, 0, 1, 5'd3, 8'h00, 1, 0, 16'd0);
        vecs[6] = mk(0, 0, 8'h00, 0, 0, 0, 5'd3, 8'h00, 0, 1, 16'd0);
        vecs[7] = mk(0, 0, 8'h00, 0, 0, 0, 5'd3, 8'h00, 0, 1, 16'd1);

        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;

        // 4-byte load, valid held high; rows are cycles 0..7 after reset release
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start; s_valid = vecs[i].s_valid;
            s_data = vecs[i].s_data; s_last = vecs[i].s_last;
            chk($sformatf("vec%0d s_ready", i),    32'(s_ready),    32'(vecs[i].e_ready));
            chk($sformatf("vec%0d mem_wr", i),     32'(mem_wr),     32'(vecs[i].e_wr));
            chk($sformatf("vec%0d mem_addr", i),   32'(mem_addr),   32'(vecs[i].e_addr));
            chk($sformatf("vec%0d mem_data", i),   32'(mem_data),   32'(vecs[i].e_data));
            chk($sformatf("vec%0d mem_sel", i),    32'(mem_sel),    32'(vecs[i].e_sel));
            chk($sformatf("vec%0d cpu_rst_n", i),  32'(cpu_rst_n),  32'(vecs[i].e_rstn));
            chk($sformatf("vec%0d done", i),       32'(done),       32'(vecs[i].e_done));
            chk($sformatf("vec%0d error", i),      32'(error),      32'(vecs[i].e_err));
            chk($sformatf("vec%0d run_cycles", i), 32'(run_cycles), 32'(vecs[i].e_rc));
            tick();
        end
        start = 1'b0; s_valid = 1'b0; s_last = 1'b0;

        // cpu_rst_n rose in cycle 6; halt raised in cycle 6+37 = 43 (now cycle 8)
        repeat (35) tick();
        chk("halt cycle run_cycles", 32'(run_cycles), 32'd37);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk("post-halt run_cycles", 32'(run_cycles), 32'd37);
        tick();
        chk("halted done", 32'(done), 32'd1);
        chk("halted cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("halted mem_sel", 32'(mem_sel), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cpu_halt = ~cpu_halt;
            tick();
        end
        cpu_halt = 1'b0;
        tick();
        chk("halt toggle done", 32'(done), 32'd1);
        chk("halt toggle run_cycles", 32'(run_cycles), 32'd37);

        // 10-byte load with random stalls, restarted from HALTED
        pulse_start();
        chk("restart done cleared", 32'(done), 32'd0);
        chk("restart cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("restart s_ready", 32'(s_ready), 32'd1);
        chk("restart run_cycles", 32'(run_cycles), 32'd0);
        wr_addr_q.delete(); wr_data_q.delete();
        load_bytes(10, 1'b1, 1'b1, 8'h30);
        wait_cpu_release("stall");
        check_writes("stall", 10, 8'h30);

        // no halt for 20 RUN cycles; start during RUN must be ignored
        chk("run start run_cycles", 32'(run_cycles), 32'd0);
        for (int k = 0; k < 20; k++) begin
            start = (k == 5);
            tick();
        end
        start = 1'b0;
        chk("run 16b run_cycles", 32'(run_cycles), 32'd20);
        chk("run 4b saturated", 32'(run_cycles4), 32'd15);
        chk("run start ignored s_ready", 32'(s_ready), 32'd0);
        chk("run start ignored cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        tick();
        tick();
        chk("second halt done", 32'(done), 32'd1);

        // 32 bytes without s_last overflows memory
        pulse_start();
        wr_addr_q.delete(); wr_data_q.delete();
        load_bytes(32, 1'b0, 1'b0, 8'h07);
        chk("ovf last write mem_wr", 32'(mem_wr), 32'd1);
        chk("ovf last write addr", 32'(mem_addr), 32'd31);
        chk("ovf error not yet", 32'(error), 32'd0);
        chk("ovf s_ready dropped", 32'(s_ready), 32'd0);
        tick();
        chk("ovf error", 32'(error), 32'd1);
        chk("ovf cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("ovf mem_sel", 32'(mem_sel), 32'd1);
        chk("ovf mem_wr done", 32'(mem_wr), 32'd0);
        check_writes("ovf", 32, 8'h07);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        tick();
        chk("ovf halt ignored done", 32'(done), 32'd0);
        chk("ovf error held", 32'(error), 32'd1);
        chk("ovf cpu_rst_n held", 32'(cpu_rst_n), 32'd0);
        pulse_start();
        chk("ovf restart error", 32'(error), 32'd0);
        chk("ovf restart s_ready", 32'(s_ready), 32'd1);

        // reset after 3 of 6 bytes, with the 4th byte offered and start raised
        wr_addr_q.delete(); wr_data_q.delete();
        load_bytes(3, 1'b0, 1'b0, 8'h50);
        s_valid = 1'b1; s_data = 8'hEE; rst = 1'b1; start = 1'b1;
        tick();
        s_valid = 1'b0; start = 1'b0;
        check_reset_vals("midrst");
        rst = 1'b0;
        tick();
        tick();
        chk("midrst writes", 32'(wr_addr_q.size()), 32'd3);
        chk("midrst idle s_ready", 32'(s_ready), 32'd0);
        pulse_start();
        wr_addr_q.delete(); wr_data_q.delete();
        load_bytes(6, 1'b1, 1'b0, 8'h60);
        wait_cpu_release("reload");
        check_writes("reload", 6, 8'h60);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_cpu_boot_loader

`default_nettype wire
